exu_muldiv_ctrl: RTL and testbench
==================================

Name: exu_muldiv_ctrl

Overview:
- Iterative RV32M multiply/divide sequencer in the execute stage, beside the single-cycle integer ALU.
- Accepts one M-extension operation, runs a 32-step shift-add multiply or restoring divide, and stalls the pipeline while busy.
- Returns a write-back result with one-cycle done strobe.
- Decode (OPCODE_ALR with func7 = 0000001) happens upstream; this block sees only func3 and operands.

Parameters:
XLEN, 32, operand/result width
XREG_ADDRWIDTH, 5, destination register index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_in  in  1  M-op present in EX; held high by upstream until completion
func3_in  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_in  in  XLEN  operand A (dividend / multiplicand)
rs2_in  in  XLEN  operand B (divisor / multiplier)
rd_addr_in  in  XREG_ADDRWIDTH  destination register
flush_in  in  1  pipeline flush; aborts operation in progress
busy_out  out  1  stall request to pipeline
done_out  out  1  one-cycle result-valid strobe
rd_out  out  XLEN  result
rd_en_out  out  1  write-back enable, equals done_out
rd_addr_out  out  XREG_ADDRWIDTH  latched destination register

Behaviour:
- One clock domain (clk). rst is synchronous and active-high.
- Reset values: state IDLE, step counter 0, all internal registers 0, busy_out 0, done_out 0, rd_out 0, rd_en_out 0, rd_addr_out 0.
- States:
  - IDLE: waits for an operation.
  - CALC: 32 iterations.
  - DONE: presents the result for one cycle.
- IDLE with start_in=1 and flush_in=0, cycle T:
  - Latch func3 and rd_addr.
  - Latch |rs1| and |rs2| per signedness:
    - MULH: both signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MUL, MULHU, DIVU, REMU: unsigned.
    - DIV, REM: both signed.
  - Latch the negate flags:
    - Product negation: sign(A) xor sign(B), over the signed operands only.
    - DIV quotient negation: sign(A) xor sign(B).
    - REM remainder negation: sign(A) only.
  - Go to CALC with counter 0.
- Divide special cases are detected in IDLE; the block goes straight to DONE, giving done_out at T+1:
  - rs2=0: quotient = all ones (0xFFFFFFFF); remainder = rs1.
  - Signed op with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC:
  - One step per cycle. Counter increments 0..31; at counter=31 go to DONE.
  - Multiply: 64-bit accumulator. If multiplier bit[i]=1, add the multiplicand shifted left by i.
  - Divide: 32-bit remainder register and quotient register. Each step shifts the next dividend bit (MSB first) into the remainder. If remainder >= divisor, subtract the divisor and set the quotient bit.
- Normal latency: start sampled at T, CALC occupies T+1..T+32, DONE at T+33.
- DONE:
  - done_out=1 and rd_en_out=1 for exactly one cycle.
  - rd_out:
    - MUL: low 32 bits of the (sign-corrected) product.
    - MULH, MULHSU, MULHU: high 32 bits of the sign-corrected 64-bit product.
    - DIV, DIVU: quotient, negated if flagged.
    - REM, REMU: remainder, negated if flagged.
  - Next state is always IDLE.
  - start_in is ignored in DONE, because the completing instruction is still present.
- busy_out is combinational: busy_out = (state==CALC) | (state==IDLE & start_in & ~flush_in). It is 0 in DONE so the pipeline advances on the result cycle.
- flush_in=1 in any state: next state IDLE, no done_out, no write-back. flush has priority over start and over DONE→output. If flush coincides with DONE, done_out is suppressed that cycle.
- Input changes on rs1_in, rs2_in and func3_in after acceptance do not affect the result.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE (T+34 earliest).
- rst has priority over flush_in and start_in, and aborts mid-operation with all outputs returning to reset values the next cycle.
- rd_out and rd_addr_out hold their last value outside DONE; only rd_en_out and done_out qualify them.

Test Plan:
- MUL 7 × −3 (rs2=0xFFFFFFFD), start at T → busy_out high T..T+32, done_out only at T+33, rd_out=0xFFFFFFEB; MULHU with the same operands → rd_out=0x00000006.
- MULH 0x80000000 × 0x80000000 → rd_out=0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → rd_out=0xFFFFFFFF.
- DIV −20/6 → 0xFFFFFFFD; REM −20/6 → 0xFFFFFFFE; DIVU 100/7 → 14; REMU 100/7 → 2; each completes at T+33.
- DIV 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM of the same operands → 0.
- flush_in pulsed at T+10 of a DIVU → state IDLE at T+11, busy_out low, no done_out; a new MUL 3×4 at T+12 → rd_out=12 with done at T+45.
- rst asserted at T+5 mid-MUL → all outputs 0 at T+6; start held through DONE of one op produces exactly one done_out pulse.

Source files
------------

// File: rtl/exu_muldiv_ctrl_if.sv
// Handshake and operand bundle between the execute stage and the multiply/divide sequencer.
// The pipeline side uses the master modport and the sequencer uses the slave modport.
interface exu_muldiv_ctrl_if #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5
);
    logic                      start_in;
    logic [2:0]                func3_in;
    logic [XLEN-1:0]           rs1_in;
    logic [XLEN-1:0]           rs2_in;
    logic [XREG_ADDRWIDTH-1:0] rd_addr_in;
    logic                      flush_in;
    logic                      busy_out;
    logic                      done_out;
    logic [XLEN-1:0]           rd_out;
    logic                      rd_en_out;
    logic [XREG_ADDRWIDTH-1:0] rd_addr_out;

    modport master (
        output start_in, func3_in, rs1_in, rs2_in, rd_addr_in, flush_in,
        input  busy_out, done_out, rd_out, rd_en_out, rd_addr_out
    );

    modport slave (
        input  start_in, func3_in, rs1_in, rs2_in, rd_addr_in, flush_in,
        output busy_out, done_out, rd_out, rd_en_out, rd_addr_out
    );
endinterface

// File: rtl/exu_muldiv_ctrl.sv
// Iterative RV32M sequencer: 32-step shift-add multiply or restoring divide on operand magnitudes,
// with the sign fixed up on the final step and a one-cycle write-back strobe.
module exu_muldiv_ctrl #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5
) (
    input logic              clk,
    input logic              rst,
    exu_muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [2:0] F_MUL = 3'b000;
    localparam logic [2:0] F_MULH = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV = 3'b100;
    localparam logic [2:0] F_REM = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                func3_q, func3_d;
    logic [XREG_ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]           opnd_q, opnd_d;
    logic [2*XLEN-1:0]         acc_q, acc_d;
    logic                      neg_q, neg_d;
    logic [XLEN-1:0]           rd_q, rd_d;

    logic            sign_a, sign_b, a_signed, b_signed, is_div_in, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [2*XLEN-1:0] step_acc, prod;
    logic [XLEN-1:0] quo, rem, result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            func3_q   <= '0;
            rd_addr_q <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func3_q   <= func3_d;
            rd_addr_q <= rd_addr_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rd_q      <= rd_d;
        end
    end

    // acc_q is {high product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        sign_a    = bus.rs1_in[XLEN-1];
        sign_b    = bus.rs2_in[XLEN-1];
        a_signed  = (bus.func3_in == F_MULH) || (bus.func3_in == F_MULHSU) ||
                    (bus.func3_in == F_DIV) || (bus.func3_in == F_REM);
        b_signed  = (bus.func3_in == F_MULH) || (bus.func3_in == F_DIV) || (bus.func3_in == F_REM);
        mag_a     = (a_signed && sign_a) ? -bus.rs1_in : bus.rs1_in;
        mag_b     = (b_signed && sign_b) ? -bus.rs2_in : bus.rs2_in;
        is_div_in = bus.func3_in[2];
        div_ovf   = is_div_in && !bus.func3_in[0] &&
                    (bus.rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_in == '1);

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
        if (!func3_q[2])
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_trial[XLEN])
            step_acc = {acc_q[2*XLEN-2:0], 1'b0};
        else
            step_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod = neg_q ? -step_acc : step_acc;
        quo  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem  = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (func3_q[2])
            result = func3_q[1] ? rem : quo;
        else if (func3_q == F_MUL)
            result = prod[XLEN-1:0];
        else
            result = prod[2*XLEN-1:XLEN];

        state_d   = state_q;
        cnt_d     = cnt_q;
        func3_d   = func3_q;
        rd_addr_d = rd_addr_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rd_d      = rd_q;

        if (bus.flush_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_in) begin
                        func3_d   = bus.func3_in;
                        rd_addr_d = bus.rd_addr_in;
                        cnt_d     = '0;
                        case (bus.func3_in)
                            F_MULH, F_DIV: neg_d = sign_a ^ sign_b;
                            F_MULHSU, F_REM: neg_d = sign_a;
                            default: neg_d = 1'b0;
                        endcase
                        if (is_div_in && (bus.rs2_in == '0)) begin
                            state_d = S_DONE;
                            rd_d    = bus.func3_in[1] ? bus.rs1_in : '1;
                        end else if (div_ovf) begin
                            state_d = S_DONE;
                            rd_d    = bus.func3_in[1] ? '0 : bus.rs1_in;
                        end else begin
                            state_d = S_CALC;
                            opnd_d  = is_div_in ? mag_b : mag_a;
                            acc_d   = {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
                        end
                    end
                end
                S_CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = S_DONE;
                        rd_d    = result;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.busy_out    = (state_q == S_CALC) ||
                             ((state_q == S_IDLE) && bus.start_in && !bus.flush_in);
    assign bus.done_out    = (state_q == S_DONE) && !bus.flush_in;
    assign bus.rd_en_out   = bus.done_out;
    assign bus.rd_out      = rd_q;
    assign bus.rd_addr_out = rd_addr_q;
endmodule

// File: tb/tb_exu_muldiv_ctrl.sv
// Directed bench for exu_muldiv_ctrl: hand-computed RV32M results, latency, flush and reset behaviour.
module tb_exu_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    exu_muldiv_ctrl_if #(.XLEN(32), .XREG_ADDRWIDTH(5)) bus ();
    exu_muldiv_ctrl #(.XLEN(32), .XREG_ADDRWIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start at the current cycle T, scramble inputs after acceptance, expect done at T+exp_lat.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        int busy_gaps;
        bus.func3_in   = f3;
        bus.rs1_in     = a;
        bus.rs2_in     = b;
        bus.rd_addr_in = rd;
        bus.start_in   = 1'b1;
        #1;
        check({tag, " busy@T"}, 64'(bus.busy_out), 64'd1);
        lat = 0;
        busy_gaps = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.done_out) begin
                lat = n;
                break;
            end
            if (!bus.busy_out) busy_gaps++;
            if (n == 1) begin
                bus.func3_in   = ~f3;
                bus.rs1_in     = ~a;
                bus.rs2_in     = a ^ b ^ 32'h5a5a_5a5a;
                bus.rd_addr_in = ~rd;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy gaps"}, 64'(busy_gaps), 64'd0);
        check({tag, " rd_out"}, 64'(bus.rd_out), 64'(exp));
        check({tag, " rd_addr"}, 64'(bus.rd_addr_out), 64'(rd));
        check({tag, " rd_en/busy@done"}, {62'd0, bus.rd_en_out, bus.busy_out}, 64'd2);
        bus.start_in = 1'b0;
        tick();
        check({tag, " done cleared"}, 64'(bus.done_out), 64'd0);
        check({tag, " rd_out held"}, 64'(bus.rd_out), 64'(exp));
    endtask

    initial begin
        int dones;
        rst            = 1'b1;
        bus.start_in   = 1'b0;
        bus.flush_in   = 1'b0;
        bus.func3_in   = 3'b000;
        bus.rs1_in     = '0;
        bus.rs2_in     = '0;
        bus.rd_addr_in = '0;
        tick();
        tick();
        check("reset outputs", {bus.busy_out, bus.done_out, bus.rd_en_out, bus.rd_out, bus.rd_addr_out},
              64'd0);
        rst = 1'b0;
        tick();

        run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
        run_op("MULHU 7*-3", 3'b011, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'h0000_0006, 33);
        run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 33);
        run_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 33);
        run_op("DIV -20/6", 3'b100, 32'hFFFF_FFEC, 32'd6, 5'd5, 32'hFFFF_FFFD, 33);
        run_op("REM -20/6", 3'b110, 32'hFFFF_FFEC, 32'd6, 5'd6, 32'hFFFF_FFFE, 33);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 33);
        run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 33);
        run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
        run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);

        // Flush a DIVU at T+10, then start a MUL at T+12.
        bus.func3_in   = 3'b101;
        bus.rs1_in     = 32'd1000;
        bus.rs2_in     = 32'd3;
        bus.rd_addr_in = 5'd13;
        bus.start_in   = 1'b1;
        dones = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (bus.done_out) dones++;
        end
        bus.flush_in = 1'b1;
        bus.start_in = 1'b0;
        #1;
        check("flush done@T+10", 64'(bus.done_out), 64'd0);
        tick();
        bus.flush_in = 1'b0;
        #1;
        check("flush busy@T+11", 64'(bus.busy_out), 64'd0);
        check("flush done@T+11", 64'(bus.done_out), 64'd0);
        check("flush early dones", 64'(dones), 64'd0);
        tick();
        run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 5'd14, 32'd12, 33);

        // Reset at T+5 of a MUL; start dropped along with it.
        bus.func3_in   = 3'b000;
        bus.rs1_in     = 32'h1234_5678;
        bus.rs2_in     = 32'd3;
        bus.rd_addr_in = 5'd15;
        bus.start_in   = 1'b1;
        for (int n = 1; n <= 5; n++) tick();
        rst          = 1'b1;
        bus.start_in = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst outputs@T+6",
              {bus.busy_out, bus.done_out, bus.rd_en_out, bus.rd_out, bus.rd_addr_out}, 64'd0);
        dones = 0;
        for (int n = 0; n < 36; n++) begin
            tick();
            if (bus.done_out) dones++;
        end
        check("rst no done", 64'(dones), 64'd0);

        // Start held through DONE of one op: exactly one strobe.
        run_op("MUL held start", 3'b000, 32'd9, 32'd9, 5'd16, 32'd81, 33);
        dones = 0;
        for (int n = 0; n < 36; n++) begin
            tick();
            if (bus.done_out) dones++;
        end
        check("single done pulse", 64'(dones), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
